// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered eight-way bitwise logic unit behind a one-stage
// elastic pipeline (valid/ready on both sides) with a wrapping delivery counter.
//
// Optional build macro: LOGIC_UNIT_FLAGS_EN
//   When defined, adds registered out_zero / out_parity status flags that
//   load, hold and reset together with the result register.
//
// op encoding: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT in1, 7 PASS in1.
// in_ready is the only combinational output (from out_ready), which lets the
// consumer drain a result while a new one is captured in the same cycle.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  // Operation codes, kept local so the decode below reads by name.
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Bitwise operation selected by op; in2 is unused for NOT and PASS.
  function automatic logic [WIDTH-1:0] logic_op_f(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Even-parity helper: XOR-reduction of a result word.
  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // All-zero detector for a result word.
  function automatic logic zero_f(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] out_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] result_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             deliver_s;

  // Handshake decode and next result; a free slot or a draining slot can accept.
  always_comb begin
    result_s   = logic_op_f(op, in1, in2);
    in_ready_s = 1'b0;
    if (!out_valid_r || out_ready) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s  = in_valid && in_ready_s;
    deliver_s = out_valid_r && out_ready;
  end

  // Result register: loads only on accept, otherwise keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      out_r <= result_s;
    end else begin
      out_r <= out_r;
    end
  end

  // Valid flag: set by accept, cleared by a delivery with no refill behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
    end else if (deliver_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Delivery counter: free-running modulo 2^CNT_W, results lost to reset are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (deliver_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_r;
  logic parity_r;

  // Status flags travel with the result word and share its load/hold/reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_r   <= 1'b0;
      parity_r <= 1'b0;
    end else if (accept_s) begin
      zero_r   <= zero_f(result_s);
      parity_r <= parity_f(result_s);
    end else begin
      zero_r   <= zero_r;
      parity_r <= parity_r;
    end
  end

  assign out_zero   = zero_r;
  assign out_parity = parity_r;
`endif

  assign in_ready  = in_ready_s;
  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8, CNT_W=4). The driver pushes
// hand-computed expected results when an accept is guaranteed; an independent
// monitor pops and compares on every delivery.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in1 = 8'h00;
  logic [7:0] in2 = 8'h00;
  logic [2:0] op  = 3'd0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic [3:0] count;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic       out_zero;
  logic       out_parity;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  logic [7:0] ops_exp [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .out_zero(out_zero), .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivery must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: delivery of 0x%0h with no expectation at %0t", out, $time);
      end else begin
        e = sb.pop_front();
        check("deliver_out", {24'd0, out}, {24'd0, e});
`ifdef LOGIC_UNIT_FLAGS_EN
        check("deliver_zero", {31'd0, out_zero}, {31'd0, (e == 8'h00)});
        check("deliver_parity", {31'd0, out_parity}, {31'd0, ^e});
`endif
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("rst_out", {24'd0, out}, 32'h00);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("rst_zero", {31'd0, out_zero}, 32'd0);
    check("rst_parity", {31'd0, out_parity}, 32'd0);
`endif
  endtask

  // Present one operand set, wait (bounded) for acceptance, then check 1-cycle latency.
  // in_valid is left high so back-to-back calls stream at full rate.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                       input logic [7:0] exp);
    bit ok = 1'b0;
    in1 = a; in2 = b; op = o; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1 at %0t", $time);
    end else begin
      sb.push_back(exp);
      @(posedge clk);
      #1;
      check("latency_valid", {31'd0, out_valid}, 32'd1);
      check("latency_out", {24'd0, out}, {24'd0, exp});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset then idle.
    do_reset(2);

    // All ops back-to-back with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(8'hC5, 8'h3A, 3'(i), ops_exp[i]);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("ops_count", {28'd0, count}, 32'd8);
    check("ops_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: AND 0xF0/0x3C held for 3 cycles while operands churn.
    out_ready = 1'b0;
    issue(8'hF0, 8'h3C, 3'd0, 8'h30);
    for (int i = 0; i < 3; i++) begin
      in1 = 8'(i * 37 + 1); in2 = 8'(i * 11 + 5); op = 3'd7; in_valid = 1'b1;
      @(negedge clk);
      check("stall_out", {24'd0, out}, 32'h30);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_count", {28'd0, count}, 32'd8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("release_count", {28'd0, count}, 32'd9);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_out_kept", {24'd0, out}, 32'h30);

    // Counter wrap: 17 deliveries from reset leave count at 1.
    do_reset(1);
    for (int i = 0; i < 17; i++) issue(8'(i + 16), 8'h00, 3'd7, 8'(i + 16));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap_count", {28'd0, count}, 32'd1);

    // Reset mid-stall discards the held result without counting it.
    out_ready = 1'b0;
    issue(8'hAA, 8'h00, 3'd7, 8'hAA);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out", {24'd0, out}, 32'hAA);
    check("pre_rst_count", {28'd0, count}, 32'd1);
    out_ready = 1'b1;
    do_reset(1);

    // Flag vectors (flags also checked by the monitor when present).
    issue(8'h5A, 8'h5A, 3'd4, 8'h00);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("flag_zero_xor", {31'd0, out_zero}, 32'd1);
    check("flag_parity_xor", {31'd0, out_parity}, 32'd0);
`endif
    issue(8'h07, 8'h00, 3'd2, 8'h07);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("flag_zero_or", {31'd0, out_zero}, 32'd0);
    check("flag_parity_or", {31'd0, out_parity}, 32'd1);
`endif
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("final_count", {28'd0, count}, 32'd2);
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
